// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
// Contents: display-region enumeration, default 640x480@60 vertical and
// horizontal timing constants, and a helper that sums a timing's region lengths.
package vga_timing_pkg;

  // Display regions in scan order.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } region_e;

  // 640x480@60 vertical timing, in lines.
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // 640x480@60 horizontal timing, in pixels.
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;

  // Total period of a timing: active + front porch + sync + back porch.
  function automatic int unsigned timing_total(input int unsigned act_len,
                                               input int unsigned fp_len,
                                               input int unsigned sync_len,
                                               input int unsigned bp_len);
    return act_len + fp_len + sync_len + bp_len;
  endfunction

endpackage

// File: rtl/vga_region_decode.sv
// Combinational region decoder shared by the horizontal and vertical timing
// generators.
// Ports:
//   count    - position within the period (line or pixel), 0..total-1
//   region_c - region containing count (ACTIVE, FRONT, SYNC, BACK)
//   sync_c   - sync level for count: SYNC_POL inside SYNC, inverted elsewhere
// A zero-length porch has coincident boundaries, so its region never decodes.
module vga_region_decode
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ACT_LEN  = V_ACTIVE_DEF,
  parameter int unsigned FP_LEN   = V_FP_DEF,
  parameter int unsigned SYNC_LEN = V_SYNC_DEF,
  parameter int unsigned BP_LEN   = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic [CNT_W-1:0] count,
  output region_e          region_c,
  output logic             sync_c
);

  localparam int unsigned TOTAL = timing_total(ACT_LEN, FP_LEN, SYNC_LEN, BP_LEN);

  // Boundaries carry one spare bit so a zero back porch ending at 2^CNT_W
  // still compares correctly.
  localparam logic [CNT_W:0] FRONT_AT = (CNT_W+1)'(ACT_LEN);
  localparam logic [CNT_W:0] SYNC_AT  = (CNT_W+1)'(ACT_LEN + FP_LEN);
  localparam logic [CNT_W:0] BACK_AT  = (CNT_W+1)'(ACT_LEN + FP_LEN + SYNC_LEN);

  // The last position of the period must be representable in count.
  generate
    if (((TOTAL - 1) >> CNT_W) != 0) begin : g_cnt_w_check
      $error("vga_region_decode: period of %0d does not fit in CNT_W=%0d", TOTAL, CNT_W);
    end
  endgenerate

  logic [CNT_W:0] count_x;
  assign count_x = {1'b0, count};

  // Region lookup by ascending boundary.
  always_comb begin
    region_c = BACK;
    if (count_x < FRONT_AT) begin
      region_c = ACTIVE;
    end else if (count_x < SYNC_AT) begin
      region_c = FRONT;
    end else if (count_x < BACK_AT) begin
      region_c = SYNC;
    end
    sync_c = (region_c == SYNC) ? SYNC_POL : ~SYNC_POL;
  end

endmodule

// File: rtl/vga_vtiming_gen.sv
// Vertical timing generator for the VGA controller.
// Advances one line per ven pulse and produces registered vertical timing.
// Ports:
//   clk, rst      - pixel clock, synchronous active-high reset
//   ven           - one-cycle line-advance strobe from the horizontal controller
//   swap_req      - level request to swap the display buffer at the next vblank
//   vcount        - current line, 0..V_TOTAL-1
//   vsync, vde    - vertical sync (VSYNC_POL asserted) and display enable
//   frame_start   - one-cycle pulse on the first cycle showing line 0
//   vblank_start  - one-cycle pulse on the first cycle showing line V_ACTIVE
//   frame_cnt     - completed frames, modulo 2^FRAME_W
//   swap_ack      - one-cycle acknowledge, coincident with vblank_start
//   buf_sel       - active display buffer, toggles with each swap_ack
module vga_vtiming_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ven,
  input  logic               swap_req,
  output logic [CNT_W-1:0]   vcount,
  output logic               vsync,
  output logic               vde,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               swap_ack,
  output logic               buf_sel
);

  localparam int unsigned     V_TOTAL     = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] LAST_LINE   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VBLANK_LINE = CNT_W'(V_ACTIVE);

  // Active video and sync must both exist for a usable frame.
  generate
    if (V_ACTIVE == 0 || V_SYNC == 0) begin : g_region_check
      $error("vga_vtiming_gen: V_ACTIVE and V_SYNC must be non-zero");
    end
  endgenerate

  region_e          state;
  region_e          state_next_c;
  region_e          region_c;
  logic [CNT_W-1:0] count_next_c;
  logic             wrap_c;
  logic             vblank_hit_c;
  logic             swap_hit_c;
  logic             sync_c;
  logic             vsync_next_c;

  // Line counter advance and the events it triggers.
  always_comb begin
    count_next_c = vcount;
    wrap_c       = 1'b0;
    vblank_hit_c = 1'b0;
    swap_hit_c   = 1'b0;
    if (ven) begin
      wrap_c       = (vcount == LAST_LINE);
      count_next_c = wrap_c ? '0 : vcount + CNT_W'(1);
      vblank_hit_c = (count_next_c == VBLANK_LINE);
      swap_hit_c   = vblank_hit_c & swap_req;
    end
  end

  // Region of the upcoming line, so registered outputs move with vcount.
  vga_region_decode #(
    .CNT_W    (CNT_W),
    .ACT_LEN  (V_ACTIVE),
    .FP_LEN   (V_FP),
    .SYNC_LEN (V_SYNC),
    .BP_LEN   (V_BP),
    .SYNC_POL (VSYNC_POL)
  ) u_decode (
    .count    (count_next_c),
    .region_c (region_c),
    .sync_c   (sync_c)
  );

  // Region FSM next state: moves only on ven, skipping empty porches via decode.
  always_comb begin
    state_next_c = state;
    vsync_next_c = vsync;
    if (ven) begin
      state_next_c = region_c;
      vsync_next_c = sync_c;
    end
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vcount       <= '0;
      state        <= ACTIVE;
      vde          <= 1'b1;
      vsync        <= ~VSYNC_POL;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_cnt    <= '0;
      swap_ack     <= 1'b0;
      buf_sel      <= 1'b0;
    end else begin
      vcount       <= count_next_c;
      state        <= state_next_c;
      vde          <= (state_next_c == ACTIVE);
      vsync        <= vsync_next_c;
      frame_start  <= wrap_c;
      vblank_start <= vblank_hit_c;
      swap_ack     <= swap_hit_c;
      if (wrap_c) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
      if (swap_hit_c) begin
        buf_sel <= ~buf_sel;
      end
    end
  end

endmodule

// File: tb/tb_vga_vtiming_gen.sv
// Self-checking bench for vga_vtiming_gen: a default 525-line instance and a
// small 6-line instance share stimulus and are compared every cycle against a
// line-index reference model, plus directed sequences and a vector table.
module tb_vga_vtiming_gen;

  localparam int D_A = 480, D_FP = 10, D_S = 2, D_BP = 33, D_T = 525;
  localparam int S_A = 4,   S_FP = 0,  S_S = 1, S_BP = 1,  S_T = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ven = 1'b0;
  logic swap_req = 1'b0;

  logic [15:0] d_vcount, s_vcount;
  logic        d_vsync, d_vde, d_fs, d_vb, d_ack, d_buf;
  logic        s_vsync, s_vde, s_fs, s_vb, s_ack, s_buf;
  logic [7:0]  d_fc;
  logic [1:0]  s_fc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_vtiming_gen dut (
    .clk(clk), .rst(rst), .ven(ven), .swap_req(swap_req),
    .vcount(d_vcount), .vsync(d_vsync), .vde(d_vde),
    .frame_start(d_fs), .vblank_start(d_vb), .frame_cnt(d_fc),
    .swap_ack(d_ack), .buf_sel(d_buf)
  );

  vga_vtiming_gen #(
    .V_ACTIVE(4), .V_FP(0), .V_SYNC(1), .V_BP(1), .VSYNC_POL(1'b1), .FRAME_W(2)
  ) dut_s (
    .clk(clk), .rst(rst), .ven(ven), .swap_req(swap_req),
    .vcount(s_vcount), .vsync(s_vsync), .vde(s_vde),
    .frame_start(s_fs), .vblank_start(s_vb), .frame_cnt(s_fc),
    .swap_ack(s_ack), .buf_sel(s_buf)
  );

  // Reference model: state is just the visible line index plus frame/buffer state.
  typedef struct {
    int line;
    int fc;
    bit bsel;
    bit fs;
    bit vb;
    bit ack;
  } model_t;

  model_t md = '{line: 0, fc: 0, bsel: 1'b0, fs: 1'b0, vb: 1'b0, ack: 1'b0};
  model_t ms = '{line: 0, fc: 0, bsel: 1'b0, fs: 1'b0, vb: 1'b0, ack: 1'b0};

  function automatic model_t model_next(input model_t m, input bit r, input bit v,
                                        input bit s, input int act, input int tot,
                                        input int fmod);
    model_t n = m;
    n.fs = 1'b0; n.vb = 1'b0; n.ack = 1'b0;
    if (r) begin
      n.line = 0; n.fc = 0; n.bsel = 1'b0;
    end else if (v) begin
      n.line = (m.line + 1) % tot;
      if (n.line == 0) begin
        n.fs = 1'b1;
        n.fc = (m.fc + 1) % fmod;
      end
      if (n.line == act) begin
        n.vb = 1'b1;
        if (s) begin
          n.ack  = 1'b1;
          n.bsel = !m.bsel;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] model_vec(input model_t m, input int act, input int fp,
                                            input int sl, input bit pol);
    bit vs, de;
    vs = (m.line >= act + fp && m.line < act + fp + sl) ? pol : !pol;
    de = (m.line < act);
    return {16'(m.line), vs, de, m.fs, m.vb, 8'(m.fc), m.ack, m.bsel, 2'b00};
  endfunction

  function automatic logic [31:0] d_vec();
    return {d_vcount, d_vsync, d_vde, d_fs, d_vb, d_fc, d_ack, d_buf, 2'b00};
  endfunction

  function automatic logic [31:0] s_vec();
    return {s_vcount, s_vsync, s_vde, s_fs, s_vb, 8'(s_fc), s_ack, s_buf, 2'b00};
  endfunction

  task automatic check_vec(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (vcount|vsync|vde|fs|vb|fc|ack|buf) t=%0t",
               name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock edge with the given inputs; both instances checked against the model.
  task automatic step(input bit r, input bit v, input bit s);
    rst = r; ven = v; swap_req = s;
    @(posedge clk);
    md = model_next(md, r, v, s, D_A, D_T, 256);
    ms = model_next(ms, r, v, s, S_A, S_T, 4);
    #1;
    check_vec("model_dflt", d_vec(), model_vec(md, D_A, D_FP, D_S, 1'b0));
    check_vec("model_small", s_vec(), model_vec(ms, S_A, S_FP, S_S, 1'b1));
  endtask

  // Dense ven until the default instance shows the target line (bounded).
  task automatic advance_to(input int target, input bit s);
    int n = 0;
    while (md.line != target && n <= D_T) begin
      step(1'b0, 1'b1, s);
      n++;
    end
    check_int("advance_to", int'(d_vcount), target);
  endtask

  typedef struct {
    bit r; bit v; bit s;
    int vc; bit vs; bit de; bit fs; bit vb; int fc; bit ack; bit bsel;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int fs_cnt, first_fs, second_fs, vs_low, vs_win, de_high, de_bad, vb_cnt, vb_line;
    int s_vs_bad, pulse_cycles, acks, ack_line, s_fs_cnt;
    int bufs[3];
    bit sreq;

    // Small-instance vectors: rst, ven, swap -> vcount vsync vde fs vb fc ack buf
    tbl[0]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 4, 1, 0, 0, 1, 0, 1, 1};
    tbl[6]  = '{0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 1};
    tbl[9]  = '{0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};

    // Reset state
    step(1'b1, 1'b0, 1'b0);
    check_int("reset_vcount", int'(d_vcount), 0);
    check_int("reset_vsync", int'(d_vsync), 1);
    check_int("reset_vde", int'(d_vde), 1);

    // Two full frames with ven every cycle
    fs_cnt = 0; first_fs = -1; second_fs = -1;
    for (int k = 1; k <= 2 * D_T; k++) begin
      step(1'b0, 1'b1, 1'b0);
      if (d_fs) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = k; else second_fs = k;
      end
      if (k == 524) check_int("seq_last_line", int'(d_vcount), 524);
    end
    check_int("frame_start_count", fs_cnt, 2);
    check_int("frame_start_first", first_fs, 525);
    check_int("frame_start_second", second_fs, 1050);
    check_int("frame_cnt_two", int'(d_fc), 2);

    // One more frame: vsync/vde windows and vblank position
    vs_low = 0; vs_win = 0; de_high = 0; de_bad = 0; vb_cnt = 0; vb_line = -1; s_vs_bad = 0;
    for (int k = 0; k < D_T; k++) begin
      step(1'b0, 1'b1, 1'b0);
      if (!d_vsync) begin
        vs_low++;
        if (d_vcount >= 16'd490 && d_vcount <= 16'd491) vs_win++;
      end
      if (d_vde) de_high++;
      if (d_vde != (d_vcount < 16'd480)) de_bad++;
      if (d_vb) begin vb_cnt++; vb_line = int'(d_vcount); end
      if (s_vsync && s_vcount != 16'd4) s_vs_bad++;
    end
    check_int("vsync_low_lines", vs_low, 2);
    check_int("vsync_low_window", vs_win, 2);
    check_int("vde_high_lines", de_high, 480);
    check_int("vde_window", de_bad, 0);
    check_int("vblank_count", vb_cnt, 1);
    check_int("vblank_line", vb_line, 480);
    check_int("small_vsync_line", s_vs_bad, 0);

    // Real line rate: ven every 800 cycles across the vblank boundary
    advance_to(476, 1'b0);
    pulse_cycles = 0;
    for (int l = 0; l < 8; l++) begin
      step(1'b0, 1'b1, 1'b0);
      if (d_vb || d_fs) pulse_cycles++;
      for (int c = 0; c < 799; c++) begin
        step(1'b0, 1'b0, 1'b0);
        if (d_vb || d_fs) pulse_cycles++;
      end
    end
    check_int("sparse_pulse_cycles", pulse_cycles, 1);
    check_int("sparse_end_line", int'(d_vcount), 484);

    // Swap raised at line 100, dropped on ack; exactly one ack at line 480
    advance_to(100, 1'b0);
    sreq = 1'b1; acks = 0; ack_line = -1;
    for (int k = 0; k < 1000; k++) begin
      step(1'b0, 1'b1, sreq);
      if (d_ack) begin
        acks++; ack_line = int'(d_vcount); sreq = 1'b0;
        check_int("swap_ack_with_vblank", int'(d_vb), 1);
      end
    end
    check_int("swap_single_ack", acks, 1);
    check_int("swap_ack_line", ack_line, 480);
    check_int("swap_buf_sel", int'(d_buf), 1);

    // Swap held for three frames from reset
    step(1'b1, 1'b0, 1'b1);
    acks = 0;
    for (int k = 0; k < 3 * D_T; k++) begin
      step(1'b0, 1'b1, 1'b1);
      if (d_ack) begin
        if (acks < 3) bufs[acks] = int'(d_buf);
        acks++;
      end
    end
    check_int("held_ack_count", acks, 3);
    check_int("held_buf_0", bufs[0], 1);
    check_int("held_buf_1", bufs[1], 0);
    check_int("held_buf_2", bufs[2], 1);

    // Reset together with ven at line 300
    advance_to(300, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_int("rst_mid_vcount", int'(d_vcount), 0);
    check_int("rst_mid_vde", int'(d_vde), 1);
    check_int("rst_mid_vsync", int'(d_vsync), 1);
    check_int("rst_mid_frame_cnt", int'(d_fc), 0);
    check_int("rst_mid_frame_start", int'(d_fs), 0);

    // Table vectors on the small instance
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s);
      check_vec($sformatf("tbl_%0d", i), s_vec(),
                {16'(tbl[i].vc), tbl[i].vs, tbl[i].de, tbl[i].fs, tbl[i].vb,
                 8'(tbl[i].fc), tbl[i].ack, tbl[i].bsel, 2'b00});
    end

    // Small instance: period 6, frame_cnt wraps 3->0 on the fourth frame
    step(1'b1, 1'b0, 1'b0);
    s_fs_cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b1, 1'b0);
      if (s_fs) begin
        s_fs_cnt++;
        check_int("small_period", k % S_T, 0);
      end
      if (k == 23) check_int("small_fc_before_wrap", int'(s_fc), 3);
    end
    check_int("small_fc_wrapped", int'(s_fc), 0);
    check_int("small_frame_starts", s_fs_cnt, 4);

    // Randomized traffic against the model
    sreq = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if ($urandom_range(0, 49) == 0) sreq = ~sreq;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, sreq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
